// File: rtl/stage_queue_pkg.sv
// Shared core package: squash age-compare used by every squash-aware stage.
package stage_queue_pkg;

    localparam int unsigned MAX_ID_W = 32;

    // An entry dies when it is the squash id or younger, i.e. the modular
    // distance (entry - squash) falls in the lower half of the id space.
    function automatic logic id_killed(input logic [MAX_ID_W-1:0] entry_id,
                                       input logic [MAX_ID_W-1:0] squash_id,
                                       input int unsigned         id_w);
        logic [MAX_ID_W-1:0] diff;
        diff = (entry_id - squash_id) >> (id_w - 1);
        return ~diff[0];
    endfunction

endpackage

// File: rtl/stage_queue.sv
// In-order staging FIFO with id-based squash. Define STAGE_QUEUE_BYPASS_EN to
// forward a push into an empty queue to the output in the same cycle.
module stage_queue
    import stage_queue_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 4,
    parameter int ID_W   = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [DATA_W-1:0]          in_data_i,
    input  logic [ID_W-1:0]            in_id_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [DATA_W-1:0]          out_data_o,
    output logic [ID_W-1:0]            out_id_o,
    input  logic                       squash_valid_i,
    input  logic [ID_W-1:0]            squash_id_i,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Handshake: a transfer happens on a rising edge where valid && ready;
    // valid never waits on ready, and in_ready_o depends on registered count only.

    logic [DATA_W-1:0] mem_data [DEPTH];
    logic [ID_W-1:0]   mem_id   [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;

    logic [CNT_W-1:0]  keep_cnt;
    logic [PTR_W-1:0]  slot;
    logic [PTR_W-1:0]  wr_base;
    logic              in_killed;
    logic              push_fire;
    logic              pop_fire;
    logic              push_eff;
    logic              pop_eff;
    logic              byp_take;

    // Killed entries always form a tail suffix, so the lowest killed index
    // from the head is the number of survivors.
    always_comb begin
        keep_cnt = count;
        slot     = rd_ptr;
        if (squash_valid_i) begin
            for (int i = DEPTH - 1; i >= 0; i--) begin
                slot = rd_ptr + PTR_W'(i);
                if (CNT_W'(i) < count &&
                    id_killed(MAX_ID_W'(mem_id[slot]), MAX_ID_W'(squash_id_i), ID_W))
                    keep_cnt = CNT_W'(i);
            end
        end
    end

    assign in_killed  = squash_valid_i &&
                        id_killed(MAX_ID_W'(in_id_i), MAX_ID_W'(squash_id_i), ID_W);
    assign in_ready_o = (count < CNT_W'(DEPTH));
    assign push_fire  = in_valid_i && in_ready_o;

`ifdef STAGE_QUEUE_BYPASS_EN
    assign byp_take    = (count == '0) && in_valid_i && !in_killed && out_ready_i;
    assign out_valid_o = (count != '0) || (in_valid_i && !in_killed);
    assign out_data_o  = (count == '0) ? in_data_i : mem_data[rd_ptr];
    assign out_id_o    = (count == '0) ? in_id_i   : mem_id[rd_ptr];
`else
    assign byp_take    = 1'b0;
    assign out_valid_o = (count != '0);
    assign out_data_o  = mem_data[rd_ptr];
    assign out_id_o    = mem_id[rd_ptr];
`endif

    // A pop only counts against a stored head that survives the squash.
    assign pop_fire = out_ready_i && (count != '0);
    assign pop_eff  = pop_fire && (keep_cnt != '0);
    assign push_eff = push_fire && !in_killed && !byp_take;
    assign wr_base  = squash_valid_i ? (rd_ptr + keep_cnt[PTR_W-1:0]) : wr_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (pop_eff)
                rd_ptr <= rd_ptr + PTR_W'(1);
            wr_ptr <= wr_base + PTR_W'(push_eff);
            count  <= keep_cnt - CNT_W'(pop_eff) + CNT_W'(push_eff);
        end
    end

    always_ff @(posedge clk) begin
        if (push_eff) begin
            mem_data[wr_base] <= in_data_i;
            mem_id[wr_base]   <= in_id_i;
        end
    end

    assign count_o = count;

endmodule

// File: tb/tb_stage_queue.sv
// Directed bench for stage_queue (DEPTH=4, ID_W=8): vector table plus
// hand-written wrap, reset, handshake and bypass sequences.
module tb_stage_queue;

    localparam int DATA_W = 64;
    localparam int DEPTH  = 4;
    localparam int ID_W   = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [ID_W-1:0]   in_id;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [ID_W-1:0]   out_id;
    logic              squash_valid;
    logic [ID_W-1:0]   squash_id;
    logic [2:0]        count;

    int checks = 0;
    int errors = 0;

    logic [ID_W-1:0] exp_q[$];

    typedef struct {
        string           name;
        logic            iv;
        logic [ID_W-1:0] iid;
        logic            ordy;
        logic            sv;
        logic [ID_W-1:0] sid;
        logic [2:0]      exp_count;
        logic [ID_W-1:0] exp_id;
    } vec_t;

    vec_t vecs[$];

    stage_queue #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ID_W(ID_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid_i     (in_valid),
        .in_ready_o     (in_ready),
        .in_data_i      (in_data),
        .in_id_i        (in_id),
        .out_valid_o    (out_valid),
        .out_ready_i    (out_ready),
        .out_data_o     (out_data),
        .out_id_o       (out_id),
        .squash_valid_i (squash_valid),
        .squash_id_i    (squash_id),
        .count_o        (count)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [DATA_W-1:0] data_of(input logic [ID_W-1:0] id);
        return {8{id ^ 8'h5A}};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input string name, input logic iv, input logic [ID_W-1:0] iid,
                       input logic ordy, input logic sv, input logic [ID_W-1:0] sid,
                       input logic [2:0] exp_count, input logic [ID_W-1:0] exp_id);
        vec_t v;
        v.name = name; v.iv = iv; v.iid = iid; v.ordy = ordy; v.sv = sv; v.sid = sid;
        v.exp_count = exp_count; v.exp_id = exp_id;
        vecs.push_back(v);
    endtask

    task automatic idle();
        in_valid     = 1'b0;
        in_id        = '0;
        in_data      = '0;
        out_ready    = 1'b0;
        squash_valid = 1'b0;
        squash_id    = '0;
    endtask

    task automatic drive(input logic iv, input logic [ID_W-1:0] iid, input logic ordy,
                         input logic sv, input logic [ID_W-1:0] sid);
        in_valid     = iv;
        in_id        = iid;
        in_data      = data_of(iid);
        out_ready    = ordy;
        squash_valid = sv;
        squash_id    = sid;
    endtask

    // driver: apply one cycle of inputs, then park inputs idle before sampling
    task automatic step(input logic iv, input logic [ID_W-1:0] iid, input logic ordy,
                        input logic sv, input logic [ID_W-1:0] sid);
        drive(iv, iid, ordy, sv, sid);
        @(posedge clk);
        #1 idle();
        #1;
    endtask

    task automatic check_state(input string name, input logic [2:0] exp_count,
                               input logic [ID_W-1:0] exp_id);
        check({name, ".count"}, 64'(count), 64'(exp_count));
        check({name, ".in_ready"}, 64'(in_ready), 64'(exp_count < 3'(DEPTH)));
        check({name, ".out_valid"}, 64'(out_valid), 64'(exp_count != 3'd0));
        if (exp_count != 3'd0) begin
            check({name, ".out_id"}, 64'(out_id), 64'(exp_id));
            check({name, ".out_data"}, out_data, data_of(exp_id));
        end
    endtask

    initial begin
        idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_state("reset", 3'd0, 8'd0);
        rst = 1'b0;
        #1;

        // name, iv, iid, ordy, sv, sid, exp_count, exp_id
        add("fill1",      1, 8'd1,   0, 0, 8'd0,   3'd1, 8'd1);
        add("fill2",      1, 8'd2,   0, 0, 8'd0,   3'd2, 8'd1);
        add("fill3",      1, 8'd3,   0, 0, 8'd0,   3'd3, 8'd1);
        add("fill4",      1, 8'd4,   0, 0, 8'd0,   3'd4, 8'd1);
        add("full_push",  1, 8'd5,   0, 0, 8'd0,   3'd4, 8'd1);
        add("drain1",     0, 8'd0,   1, 0, 8'd0,   3'd3, 8'd2);
        add("drain2",     0, 8'd0,   1, 0, 8'd0,   3'd2, 8'd3);
        add("drain3",     0, 8'd0,   1, 0, 8'd0,   3'd1, 8'd4);
        add("drain4",     0, 8'd0,   1, 0, 8'd0,   3'd0, 8'd0);
        add("empty_pop",  0, 8'd0,   1, 0, 8'd0,   3'd0, 8'd0);
        add("psq_p5",     1, 8'd5,   0, 0, 8'd0,   3'd1, 8'd5);
        add("psq_p6",     1, 8'd6,   0, 0, 8'd0,   3'd2, 8'd5);
        add("psq_p7",     1, 8'd7,   0, 0, 8'd0,   3'd3, 8'd5);
        add("psq_p8",     1, 8'd8,   0, 0, 8'd0,   3'd4, 8'd5);
        add("psq_sq7",    0, 8'd0,   0, 1, 8'd7,   3'd2, 8'd5);
        add("psq_p9",     1, 8'd9,   0, 0, 8'd0,   3'd3, 8'd5);
        add("psq_pop5",   0, 8'd0,   1, 0, 8'd0,   3'd2, 8'd6);
        add("psq_pop6",   0, 8'd0,   1, 0, 8'd0,   3'd1, 8'd9);
        add("psq_pop9",   0, 8'd0,   1, 0, 8'd0,   3'd0, 8'd0);
        add("wid_p254",   1, 8'd254, 0, 0, 8'd0,   3'd1, 8'd254);
        add("wid_p255",   1, 8'd255, 0, 0, 8'd0,   3'd2, 8'd254);
        add("wid_p0",     1, 8'd0,   0, 0, 8'd0,   3'd3, 8'd254);
        add("wid_sq255",  0, 8'd0,   0, 1, 8'd255, 3'd1, 8'd254);
        add("wid_pop",    0, 8'd0,   1, 0, 8'd0,   3'd0, 8'd0);
        add("sc_p30",     1, 8'd30,  0, 0, 8'd0,   3'd1, 8'd30);
        add("sc_p31",     1, 8'd31,  0, 0, 8'd0,   3'd2, 8'd30);
        add("sc_p32",     1, 8'd32,  0, 0, 8'd0,   3'd3, 8'd30);
        add("sc_p33",     1, 8'd33,  0, 0, 8'd0,   3'd4, 8'd30);
        add("sc_popsq30", 0, 8'd0,   1, 1, 8'd30,  3'd0, 8'd0);
        add("sp_p40",     1, 8'd40,  0, 0, 8'd0,   3'd1, 8'd40);
        add("sp_p41",     1, 8'd41,  0, 0, 8'd0,   3'd2, 8'd40);
        add("sp_sq41_p42",1, 8'd42,  0, 1, 8'd41,  3'd1, 8'd40);
        add("sp_sq45_p43",1, 8'd43,  1, 1, 8'd45,  3'd1, 8'd43);
        add("sp_pop43",   0, 8'd0,   1, 0, 8'd0,   3'd0, 8'd0);

        for (int k = 0; k < vecs.size(); k++) begin
            step(vecs[k].iv, vecs[k].iid, vecs[k].ordy, vecs[k].sv, vecs[k].sid);
            check_state(vecs[k].name, vecs[k].exp_count, vecs[k].exp_id);
        end

        // continuous push+pop through pointer wrap, order tracked by exp_q
        step(1, 8'd100, 0, 0, 8'd0);
        exp_q.push_back(8'd100);
        for (int k = 1; k <= 10; k++) begin
            drive(1, ID_W'(100 + k), 1, 0, 8'd0);
            #1;
            check("wrap.out_valid", 64'(out_valid), 64'd1);
            check("wrap.out_id", 64'(out_id), 64'(exp_q[0]));
            @(posedge clk);
            void'(exp_q.pop_front());
            exp_q.push_back(ID_W'(100 + k));
            #1 idle();
            #1;
            check("wrap.count", 64'(count), 64'd1);
        end
        check("wrap.last_id", 64'(out_id), 64'(exp_q[0]));
        step(0, 8'd0, 1, 0, 8'd0);
        void'(exp_q.pop_front());
        check("wrap.empty", 64'(count), 64'(exp_q.size()));

        // in_ready must not follow out_ready while full
        for (int k = 0; k < DEPTH; k++) step(1, ID_W'(60 + k), 0, 0, 8'd0);
        out_ready = 1'b1;
        #1;
        check("full.in_ready_with_ordy", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1 idle();
        #1;
        check_state("full.pop", 3'd3, 8'd61);

        // reset mid-operation discards live entries
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_state("rst_mid", 3'd0, 8'd0);
        rst = 1'b0;
        step(1, 8'd72, 0, 0, 8'd0);
        check_state("rst_after_push", 3'd1, 8'd72);
        step(0, 8'd0, 1, 0, 8'd0);
        check_state("rst_after_pop", 3'd0, 8'd0);

`ifdef STAGE_QUEUE_BYPASS_EN
        drive(1, 8'd3, 1, 0, 8'd0);
        #1;
        check("byp.out_valid", 64'(out_valid), 64'd1);
        check("byp.out_id", 64'(out_id), 64'd3);
        check("byp.out_data", out_data, data_of(8'd3));
        @(posedge clk);
        #1 idle();
        #1;
        check_state("byp.after", 3'd0, 8'd0);
        drive(1, 8'd4, 1, 1, 8'd4);
        #1;
        check("byp.squashed_valid", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1 idle();
        #1;
        check_state("byp.squash_after", 3'd0, 8'd0);
`else
        drive(1, 8'd80, 0, 0, 8'd0);
        #1;
        check("nobyp.same_cycle_valid", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1 idle();
        #1;
        check_state("nobyp.next_cycle", 3'd1, 8'd80);
        step(0, 8'd0, 1, 0, 8'd0);
        check_state("nobyp.pop", 3'd0, 8'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
